// File: rtl/bus_responder.sv
// bus_responder
//   Single-clock responder for the processor memory bus. Decodes each
//   address/wr_enable/wr_data cycle and returns registered read data from
//   on-chip RAM, a fixed vector ROM, or an I/O page with an interval timer.
//
//   Optional feature macro: BUS_RESPONDER_TIMER_EN
//     defined   : timer, I/O registers and irq are implemented
//     undefined : I/O page reads as unmapped (8'hFF), irq tied to 0
//
// Ports:
//   clk        in   1   single clock, rising edge
//   resetn     in   1   asynchronous active-low reset
//   address    in  16   bus address
//   wr_enable  in   1   write strobe
//   wr_data    in   8   write data
//   rd_data    out  8   registered read data (1-cycle latency)
//   irq        out  1   registered level interrupt request
module bus_responder #(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] IO_BASE   = 16'hD000,
  parameter logic [15:0] RESET_VEC = 16'h0200,
  parameter logic [15:0] NMI_VEC   = 16'h0300,
  parameter logic [15:0] IRQ_VEC   = 16'h0400,
  parameter int          PRESCALE  = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic        wr_enable,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        irq
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  // ---------------------------------------------------------------------
  // Address decode (first match wins)
  // ---------------------------------------------------------------------
  logic ram_hit;
  logic io_hit;
  logic vec_hit;

  assign ram_hit = ((address >> RAM_AW) == 16'd0);
  assign io_hit  = !ram_hit && (address[15:8] == IO_BASE[15:8]);
  assign vec_hit = !ram_hit && !io_hit && (address >= 16'hFFFA);

  // ---------------------------------------------------------------------
  // RAM: not reset; a write during reset is dropped
  // ---------------------------------------------------------------------
  logic [7:0]        mem [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx;

  assign ram_idx = address[RAM_AW-1:0];

  always_ff @(posedge clk) begin
    if (resetn && wr_enable && ram_hit)
      mem[ram_idx] <= wr_data;
  end

  // ---------------------------------------------------------------------
  // Vector ROM, little-endian
  // ---------------------------------------------------------------------
  logic [7:0] vec_rd;

  always_comb begin
    vec_rd = 8'hFF;
    case (address[2:0])
      3'b010:  vec_rd = NMI_VEC[7:0];
      3'b011:  vec_rd = NMI_VEC[15:8];
      3'b100:  vec_rd = RESET_VEC[7:0];
      3'b101:  vec_rd = RESET_VEC[15:8];
      3'b110:  vec_rd = IRQ_VEC[7:0];
      3'b111:  vec_rd = IRQ_VEC[15:8];
      default: vec_rd = 8'hFF;
    endcase
  end

`ifdef BUS_RESPONDER_TIMER_EN
  // ---------------------------------------------------------------------
  // Interval timer
  // ---------------------------------------------------------------------
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [7:0]    tload;
  logic [7:0]    tcount;
  logic          en;
  logic          auto_rl;
  logic          irq_en;
  logic          expired;
  logic [PW-1:0] presc;
  logic          irq_q;

  logic       io_wr;
  logic       wr_tload;
  logic       wr_tctrl;
  logic       wr_tstat;
  logic       tick;
  logic [7:0] io_rd;

  assign io_wr    = wr_enable && io_hit;
  assign wr_tload = io_wr && (address[7:0] == 8'h00);
  assign wr_tctrl = io_wr && (address[7:0] == 8'h02);
  assign wr_tstat = io_wr && (address[7:0] == 8'h03);
  assign tick     = en && (presc == PW'(PRESCALE - 1));

  // Statement order encodes the collision priorities: the W1C clear comes
  // before the expiry set, and TCTRL/TLOAD writes come after the tick so
  // they override its EN clear, reload and decrement.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tload   <= '0;
      tcount  <= '0;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      irq_en  <= 1'b0;
      expired <= 1'b0;
      presc   <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_tstat && wr_data[0])
        expired <= 1'b0;

      if (tick) begin
        presc <= '0;
        if (tcount != 8'd0) begin
          tcount <= tcount - 8'd1;
        end else begin
          expired <= 1'b1;
          if (auto_rl)
            tcount <= tload;
          else
            en <= 1'b0;
        end
      end else if (en) begin
        presc <= presc + 1'b1;
      end

      if (wr_tctrl) begin
        en      <= wr_data[0];
        auto_rl <= wr_data[1];
        irq_en  <= wr_data[7];
        if (wr_data[0] && !en)
          presc <= '0;
      end

      if (wr_tload) begin
        tload  <= wr_data;
        tcount <= wr_data;
        presc  <= '0;
      end

      irq_q <= expired & irq_en;
    end
  end

  assign irq = irq_q;

  always_comb begin
    io_rd = 8'h00;
    case (address[7:0])
      8'h00:   io_rd = tload;
      8'h01:   io_rd = tcount;
      8'h02:   io_rd = {irq_en, 5'b00000, auto_rl, en};
      8'h03:   io_rd = {7'b0000000, expired};
      default: io_rd = 8'h00;
    endcase
  end
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Read data register
  // ---------------------------------------------------------------------
  logic [7:0] rd_next;

  always_comb begin
    rd_next = 8'hFF;
    if (ram_hit)
      rd_next = wr_enable ? wr_data : mem[ram_idx];
`ifdef BUS_RESPONDER_TIMER_EN
    else if (io_hit)
      rd_next = io_rd;
`endif
    else if (vec_hit)
      rd_next = vec_rd;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rd_data <= '0;
    else
      rd_data <= rd_next;
  end

endmodule
